// File: rtl/pong_uart_pkg.sv
// Shared constants, frame-state encoding and small helpers for the paddle UART link.
// The optional PAD_UART_SMOOTH_EN build uses SMOOTH_STEP.
package pong_uart_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam logic [9:0] Y_MAX_DEF     = 10'd668;
    localparam logic [9:0] Y_RESET_DEF   = 10'd334;
    localparam logic [9:0] SMOOTH_STEP   = 10'd8;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        GET_HI    = 2'd1,
        GET_LO    = 2'd2,
        GET_CHK   = 2'd3
    } frame_state_e;

    function automatic logic [9:0] clamp_y(input logic [9:0] y, input logic [9:0] y_max);
        return (y > y_max) ? y_max : y;
    endfunction

    function automatic logic [7:0] frame_chk(input logic [7:0] sync_b,
                                             input logic [7:0] hi_b,
                                             input logic [7:0] lo_b);
        return sync_b ^ hi_b ^ lo_b;
    endfunction

endpackage

// File: rtl/pad_link_watchdog.sv
// Link-health timer: link_up rises on a good frame and falls after LINK_TIMEOUT
// timing ticks without one. The timer saturates so it never wraps back to "alive".
module pad_link_watchdog #(
    parameter int LINK_TIMEOUT = 60
) (
    input  logic clk,
    input  logic rst,
    input  logic timing_tick,
    input  logic good_frame,
    output logic link_up
);

    localparam int            TW    = $clog2(LINK_TIMEOUT + 1);
    localparam logic [TW-1:0] T_MAX = TW'(LINK_TIMEOUT);

    logic [TW-1:0] tmr_q;
    logic [TW-1:0] tmr_d;
    logic          link_q;
    logic          link_d;

    // Next-state for the timer and link flag; a good frame outranks a tick in the same cycle.
    always_comb begin
        tmr_d  = tmr_q;
        link_d = link_q;
        if (good_frame) begin
            tmr_d  = '0;
            link_d = 1'b1;
        end else if (timing_tick && (tmr_q != T_MAX)) begin
            tmr_d = tmr_q + TW'(1);
            if (tmr_d == T_MAX) begin
                link_d = 1'b0;
            end else begin
                link_d = link_q;
            end
        end else begin
            tmr_d  = tmr_q;
            link_d = link_q;
        end
    end

    // Timer and link flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr_q  <= '0;
            link_q <= 1'b0;
        end else begin
            tmr_q  <= tmr_d;
            link_q <= link_d;
        end
    end

    assign link_up = link_q;

endmodule

// File: rtl/pad_uart_decoder.sv
// Parses 4-byte UART frames (SYNC, Y_HI, Y_LO, CHK) into the player-2 paddle position.
// Define PAD_UART_SMOOTH_EN to slew the output toward each accepted value per timing tick.
module pad_uart_decoder
    import pong_uart_pkg::*;
#(
    parameter logic [9:0] Y_MAX        = Y_MAX_DEF,
    parameter logic [9:0] Y_RESET      = Y_RESET_DEF,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter int         LINK_TIMEOUT = 60,
    parameter int         BYTE_TIMEOUT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       timing_tick,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [9:0] y_pad_uart,
    output logic       y_valid,
    output logic       link_up,
    output logic [7:0] frame_err_cnt
);

    localparam int            BW     = $clog2(BYTE_TIMEOUT + 1);
    localparam logic [BW-1:0] BT_MAX = BW'(BYTE_TIMEOUT);

    frame_state_e  state_q, state_d;
    logic [7:0]    hi_q, hi_d;
    logic [7:0]    lo_q, lo_d;
    logic [BW-1:0] btmr_q, btmr_d;
    logic [7:0]    err_cnt_q;
    logic [9:0]    y_q;
    logic          y_valid_q;
    logic          byte_to_s;
    logic          good_frame_s;
    logic          frame_err_s;
    logic [9:0]    rx_y_s;

    // A byte in the same cycle as a tick wins, so the watchdog only fires on idle ticks.
    assign byte_to_s = (state_q != WAIT_SYNC) && !rx_valid && timing_tick &&
                       ((btmr_q + BW'(1)) == BT_MAX);
    assign rx_y_s    = clamp_y({hi_q[1:0], lo_q}, Y_MAX);

    // Frame state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= WAIT_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame next-state; a sync value mid-frame is plain data, misalignment recovers via checks.
    always_comb begin
        state_d = state_q;
        if (rx_valid) begin
            case (state_q)
                WAIT_SYNC: state_d = (rx_data == SYNC_BYTE) ? GET_HI : WAIT_SYNC;
                GET_HI:    state_d = (rx_data[7:2] != 6'd0) ? WAIT_SYNC : GET_LO;
                GET_LO:    state_d = GET_CHK;
                GET_CHK:   state_d = WAIT_SYNC;
                default:   state_d = WAIT_SYNC;
            endcase
        end else if (byte_to_s) begin
            state_d = WAIT_SYNC;
        end else begin
            state_d = state_q;
        end
    end

    // Frame outputs: byte latches, inter-byte timer, accept and reject strobes.
    always_comb begin
        hi_d         = hi_q;
        lo_d         = lo_q;
        btmr_d       = btmr_q;
        good_frame_s = 1'b0;
        frame_err_s  = 1'b0;
        if ((state_q == WAIT_SYNC) || rx_valid) begin
            btmr_d = '0;
        end else if (timing_tick) begin
            btmr_d = byte_to_s ? '0 : (btmr_q + BW'(1));
        end else begin
            btmr_d = btmr_q;
        end
        if (rx_valid) begin
            case (state_q)
                WAIT_SYNC: frame_err_s = 1'b0;
                GET_HI: begin
                    if (rx_data[7:2] != 6'd0) begin
                        frame_err_s = 1'b1;
                    end else begin
                        hi_d = rx_data;
                    end
                end
                GET_LO:    lo_d = rx_data;
                GET_CHK: begin
                    if (rx_data == frame_chk(SYNC_BYTE, hi_q, lo_q)) begin
                        good_frame_s = 1'b1;
                    end else begin
                        frame_err_s = 1'b1;
                    end
                end
                default:   frame_err_s = 1'b0;
            endcase
        end else if (byte_to_s) begin
            frame_err_s = 1'b1;
        end else begin
            frame_err_s = 1'b0;
        end
    end

    // Frame datapath registers and the saturating reject counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q      <= 8'h00;
            lo_q      <= 8'h00;
            btmr_q    <= '0;
            err_cnt_q <= 8'h00;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            btmr_q <= btmr_d;
            if (frame_err_s && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end else begin
                err_cnt_q <= err_cnt_q;
            end
        end
    end

`ifdef PAD_UART_SMOOTH_EN
    logic [9:0] target_q;
    logic [9:0] step_y_s;

    // One bounded step toward the target, landing exactly on it when close.
    always_comb begin
        step_y_s = y_q;
        if (y_q < target_q) begin
            step_y_s = ((target_q - y_q) > SMOOTH_STEP) ? (y_q + SMOOTH_STEP) : target_q;
        end else if (y_q > target_q) begin
            step_y_s = ((y_q - target_q) > SMOOTH_STEP) ? (y_q - SMOOTH_STEP) : target_q;
        end else begin
            step_y_s = y_q;
        end
    end

    // Accepted frames set the target; the visible position slews on ticks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            target_q  <= Y_RESET;
            y_q       <= Y_RESET;
            y_valid_q <= 1'b0;
        end else begin
            target_q  <= good_frame_s ? rx_y_s : target_q;
            y_q       <= timing_tick ? step_y_s : y_q;
            y_valid_q <= timing_tick && (step_y_s != y_q);
        end
    end
`else
    // Accepted frames update the position directly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y_q       <= Y_RESET;
            y_valid_q <= 1'b0;
        end else begin
            y_q       <= good_frame_s ? rx_y_s : y_q;
            y_valid_q <= good_frame_s;
        end
    end
`endif

    pad_link_watchdog #(
        .LINK_TIMEOUT(LINK_TIMEOUT)
    ) u_link_wd (
        .clk        (clk),
        .rst        (rst),
        .timing_tick(timing_tick),
        .good_frame (good_frame_s),
        .link_up    (link_up)
    );

    assign y_pad_uart    = y_q;
    assign y_valid       = y_valid_q;
    assign frame_err_cnt = err_cnt_q;

endmodule
